bp_cce_single_lce: RTL and testbench

- Minimal directory-less CCE that terminates the LCE-CCE protocol for exactly one attached LCE (lce_id 0).
- Initializes the LCE: clears all sets, then exchanges sync/sync_ack.
- Services cached read misses (with dirty-victim writeback), uncached loads and uncached stores against a memory port.
- Provides standalone single-core and unit-test coherence termination in place of the full CCE.

---
 rtl/bp_cce_single_lce.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_bp_cce_single_lce.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_single_lce.sv
// Directory-less CCE terminating the LCE-CCE protocol for one LCE (id 0).
// Ports: clk_i/reset_i, cce_id_i, lce_req/resp in, lce_cmd out, mem_cmd out, mem_resp in.
//
// Message layouts (MSB..LSB):
//   lce_req  : {uc_data[63:0], uc_size[2:0], lru_dirty, lru_way, non_excl, addr, type[1:0]}
//              type: 0 rd_miss, 1 uc_rd, 2 uc_wr
//   lce_resp : {data[block], addr, type[1:0]}
//              type: 0 sync_ack, 1 coh_ack, 2 resp_wb, 3 resp_null_wb
//   lce_cmd  : {data[block], state[1:0], way, addr, src_id, dst_id, type[2:0]}
//              type: 0 sync, 1 set_clear, 2 writeback, 3 data_and_tag, 4 uc_data, 5 uc_st_done
//              state: 0 I, 1 S, 2 E
//   mem msg  : {data[block], size[2:0], addr, type[1:0]}
//              type: 0 rd, 1 wr, 2 uc_rd, 3 uc_wr; size is log2(bytes)
// paddr/id widths stand in for the processor config.
module bp_cce_single_lce
  #(parameter int paddr_width_p  = 40
   ,parameter int lce_id_width_p = 2
   ,parameter int cce_id_width_p = 2
   ,parameter int sets_p         = 64
   ,parameter int assoc_p        = 8
   ,parameter int block_width_p  = 512
   ,localparam int way_w_lp = (assoc_p > 1) ? $clog2(assoc_p) : 1
   ,localparam int lg_blk_lp = $clog2(block_width_p/8)
   ,localparam int lce_req_msg_width_lp =
      64 + 3 + 1 + way_w_lp + 1 + paddr_width_p + 2
   ,localparam int lce_resp_msg_width_lp =
      block_width_p + paddr_width_p + 2
   ,localparam int lce_cmd_msg_width_lp =
      block_width_p + 2 + way_w_lp + paddr_width_p
      + cce_id_width_p + lce_id_width_p + 3
   ,localparam int cce_mem_msg_width_lp =
      block_width_p + 3 + paddr_width_p + 2)
  (input  logic                             clk_i
  ,input  logic                             reset_i
  ,input  logic [cce_id_width_p-1:0]        cce_id_i
  ,input  logic [lce_req_msg_width_lp-1:0]  lce_req_i
  ,input  logic                             lce_req_v_i
  ,output logic                             lce_req_yumi_o
  ,input  logic [lce_resp_msg_width_lp-1:0] lce_resp_i
  ,input  logic                             lce_resp_v_i
  ,output logic                             lce_resp_yumi_o
  ,output logic [lce_cmd_msg_width_lp-1:0]  lce_cmd_o
  ,output logic                             lce_cmd_v_o
  ,input  logic                             lce_cmd_yumi_i
  ,output logic [cce_mem_msg_width_lp-1:0]  mem_cmd_o
  ,output logic                             mem_cmd_v_o
  ,input  logic                             mem_cmd_ready_and_i
  ,input  logic [cce_mem_msg_width_lp-1:0]  mem_resp_i
  ,input  logic                             mem_resp_v_i
  ,output logic                             mem_resp_yumi_o
  );

  localparam int P = paddr_width_p;
  localparam int W = way_w_lp;
  localparam int B = block_width_p;
  localparam int cnt_w_lp = $clog2(sets_p) + 1;
  localparam logic [2:0] blk_size_lp = 3'(lg_blk_lp);

  localparam logic [1:0] req_rd_miss = 2'd0;
  localparam logic [1:0] req_uc_rd   = 2'd1;
  localparam logic [1:0] req_uc_wr   = 2'd2;

  localparam logic [1:0] rsp_sync_ack = 2'd0;
  localparam logic [1:0] rsp_coh_ack  = 2'd1;
  localparam logic [1:0] rsp_wb       = 2'd2;
  localparam logic [1:0] rsp_null_wb  = 2'd3;

  localparam logic [2:0] cmd_sync     = 3'd0;
  localparam logic [2:0] cmd_clear    = 3'd1;
  localparam logic [2:0] cmd_wb       = 3'd2;
  localparam logic [2:0] cmd_dt       = 3'd3;
  localparam logic [2:0] cmd_uc_data  = 3'd4;
  localparam logic [2:0] cmd_uc_done  = 3'd5;

  localparam logic [1:0] coh_i = 2'd0;
  localparam logic [1:0] coh_s = 2'd1;
  localparam logic [1:0] coh_e = 2'd2;

  localparam logic [1:0] mem_rd    = 2'd0;
  localparam logic [1:0] mem_wr    = 2'd1;
  localparam logic [1:0] mem_uc_rd = 2'd2;
  localparam logic [1:0] mem_uc_wr = 2'd3;

  typedef enum logic [3:0] {
    e_reset, e_clear, e_sync, e_sync_ack,
    e_ready, e_wb_cmd, e_wb_resp, e_wb_mem,
    e_wb_ack, e_mem_rd, e_mem_rd_resp, e_fill,
    e_coh_ack, e_mem_wr, e_mem_wr_ack, e_uc_done
  } state_e;

  state_e state_q, state_d;
  logic [cnt_w_lp-1:0] set_cnt_q;
  logic [1:0]   req_type_q;
  logic [P-1:0] req_addr_q;
  logic [W-1:0] req_way_q;
  logic         req_dirty_q;
  logic         req_nx_q;
  logic [2:0]   req_size_q;
  logic [63:0]  req_data_q;
  logic [P-1:0] wb_addr_q;
  logic [B-1:0] data_q;

  wire [1:0]   in_req_type  = lce_req_i[1:0];
  wire [P-1:0] in_req_addr  = lce_req_i[2 +: P];
  wire         in_req_nx    = lce_req_i[2+P];
  wire [W-1:0] in_req_way   = lce_req_i[3+P +: W];
  wire         in_req_dirty = lce_req_i[3+P+W];
  wire [2:0]   in_req_size  = lce_req_i[4+P+W +: 3];
  wire [63:0]  in_req_data  = lce_req_i[7+P+W +: 64];

  wire [1:0]   rsp_type = lce_resp_i[1:0];
  wire [P-1:0] rsp_addr = lce_resp_i[2 +: P];
  wire [B-1:0] rsp_data = lce_resp_i[2+P +: B];

  wire [B-1:0] mresp_data = mem_resp_i[5+P +: B];
  logic unused_mresp;
  assign unused_mresp = ^mem_resp_i[4+P:0];

  wire [P-1:0] blk_addr =
    {req_addr_q[P-1:lg_blk_lp], {lg_blk_lp{1'b0}}};
  wire [P-1:0] set_addr = P'(set_cnt_q) << lg_blk_lp;
  wire last_set = (set_cnt_q == cnt_w_lp'(sets_p - 1));
  wire is_miss = (req_type_q == req_rd_miss);

  logic [2:0]   c_type;
  logic [P-1:0] c_addr;
  logic [W-1:0] c_way;
  logic [1:0]   c_state;
  logic [B-1:0] c_data;
  logic [1:0]   m_type;
  logic [P-1:0] m_addr;
  logic [2:0]   m_size;
  logic [B-1:0] m_data;

  assign lce_cmd_o = {c_data, c_state, c_way, c_addr,
                      cce_id_i, {lce_id_width_p{1'b0}}, c_type};
  assign mem_cmd_o = {m_data, m_size, m_addr, m_type};

  always_comb begin
    state_d = state_q;
    lce_req_yumi_o = 1'b0;
    lce_resp_yumi_o = 1'b0;
    mem_resp_yumi_o = 1'b0;
    lce_cmd_v_o = 1'b0;
    mem_cmd_v_o = 1'b0;
    c_type = cmd_sync;
    c_addr = '0;
    c_way = '0;
    c_state = coh_i;
    c_data = '0;
    m_type = mem_rd;
    m_addr = '0;
    m_size = '0;
    m_data = '0;
    unique case (state_q)
      e_reset: state_d = e_clear;
      e_clear: begin
        lce_cmd_v_o = 1'b1;
        c_type = cmd_clear;
        c_addr = set_addr;
        if (lce_cmd_yumi_i && last_set) state_d = e_sync;
      end
      e_sync: begin
        lce_cmd_v_o = 1'b1;
        if (lce_cmd_yumi_i) state_d = e_sync_ack;
      end
      e_sync_ack: begin
        if (lce_resp_v_i && rsp_type == rsp_sync_ack) begin
          lce_resp_yumi_o = 1'b1;
          state_d = e_ready;
        end
      end
      e_ready: begin
        lce_req_yumi_o = lce_req_v_i;
        if (lce_req_v_i) begin
          if (in_req_type == req_rd_miss)
            state_d = in_req_dirty ? e_wb_cmd : e_mem_rd;
          else if (in_req_type == req_uc_rd)
            state_d = e_mem_rd;
          else if (in_req_type == req_uc_wr)
            state_d = e_mem_wr;
        end
      end
      e_wb_cmd: begin
        lce_cmd_v_o = 1'b1;
        c_type = cmd_wb;
        c_addr = blk_addr;
        c_way = req_way_q;
        if (lce_cmd_yumi_i) state_d = e_wb_resp;
      end
      e_wb_resp: begin
        if (lce_resp_v_i && rsp_type == rsp_wb) begin
          lce_resp_yumi_o = 1'b1;
          state_d = e_wb_mem;
        end else if (lce_resp_v_i && rsp_type == rsp_null_wb) begin
          lce_resp_yumi_o = 1'b1;
          state_d = e_mem_rd;
        end
      end
      e_wb_mem: begin
        mem_cmd_v_o = 1'b1;
        m_type = mem_wr;
        m_addr = wb_addr_q;
        m_size = blk_size_lp;
        m_data = data_q;
        if (mem_cmd_ready_and_i) state_d = e_wb_ack;
      end
      e_wb_ack: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) state_d = e_mem_rd;
      end
      e_mem_rd: begin
        mem_cmd_v_o = 1'b1;
        m_type = is_miss ? mem_rd : mem_uc_rd;
        m_addr = is_miss ? blk_addr : req_addr_q;
        m_size = is_miss ? blk_size_lp : req_size_q;
        if (mem_cmd_ready_and_i) state_d = e_mem_rd_resp;
      end
      e_mem_rd_resp: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) state_d = e_fill;
      end
      e_fill: begin
        lce_cmd_v_o = 1'b1;
        c_data = data_q;
        if (is_miss) begin
          c_type = cmd_dt;
          c_addr = blk_addr;
          c_way = req_way_q;
          c_state = req_nx_q ? coh_s : coh_e;
          if (lce_cmd_yumi_i) state_d = e_coh_ack;
        end else begin
          c_type = cmd_uc_data;
          c_addr = req_addr_q;
          if (lce_cmd_yumi_i) state_d = e_ready;
        end
      end
      e_coh_ack: begin
        if (lce_resp_v_i && rsp_type == rsp_coh_ack) begin
          lce_resp_yumi_o = 1'b1;
          state_d = e_ready;
        end
      end
      e_mem_wr: begin
        mem_cmd_v_o = 1'b1;
        m_type = mem_uc_wr;
        m_addr = req_addr_q;
        m_size = req_size_q;
        m_data = B'(req_data_q);
        if (mem_cmd_ready_and_i) state_d = e_mem_wr_ack;
      end
      e_mem_wr_ack: begin
        mem_resp_yumi_o = mem_resp_v_i;
        if (mem_resp_v_i) state_d = e_uc_done;
      end
      e_uc_done: begin
        lce_cmd_v_o = 1'b1;
        c_type = cmd_uc_done;
        c_addr = req_addr_q;
        if (lce_cmd_yumi_i) state_d = e_ready;
      end
      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_reset;
      set_cnt_q <= '0;
      req_type_q <= '0;
      req_addr_q <= '0;
      req_way_q <= '0;
      req_dirty_q <= 1'b0;
      req_nx_q <= 1'b0;
      req_size_q <= '0;
      req_data_q <= '0;
      wb_addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == e_clear && lce_cmd_yumi_i)
        set_cnt_q <= set_cnt_q + 1'b1;
      if (lce_req_yumi_o) begin
        req_type_q <= in_req_type;
        req_addr_q <= in_req_addr;
        req_way_q <= in_req_way;
        req_dirty_q <= in_req_dirty;
        req_nx_q <= in_req_nx;
        req_size_q <= in_req_size;
        req_data_q <= in_req_data;
      end
      if (state_q == e_wb_resp && lce_resp_yumi_o
          && rsp_type == rsp_wb) begin
        data_q <= rsp_data;
        wb_addr_q <= rsp_addr;
      end
      if (state_q == e_mem_rd_resp && mem_resp_yumi_o)
        data_q <= mresp_data;
    end
  end

endmodule

// File: tb/tb_bp_cce_single_lce.sv
// Bench for bp_cce_single_lce: acts as LCE and memory, predicts command streams.
// Ports: drives all DUT inputs, checks lce_cmd/mem_cmd and yumi behaviour.
module tb_bp_cce_single_lce;
  localparam int P = 40, W = 3, B = 512, C = 2, L = 2;
  localparam int SETS = 64;
  localparam int REQW = 64 + 3 + 1 + W + 1 + P + 2;
  localparam int RSPW = B + P + 2;
  localparam int CMDW = B + 2 + W + P + C + L + 3;
  localparam int MEMW = B + 3 + P + 2;
  localparam logic [C-1:0] CCE = 2'h2;
  typedef logic [599:0] msg_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [C-1:0] cce_id_i = CCE;
  logic [REQW-1:0] lce_req_i = '0;
  logic lce_req_v_i = 1'b0, lce_req_yumi_o;
  logic [RSPW-1:0] lce_resp_i = '0;
  logic lce_resp_v_i = 1'b0, lce_resp_yumi_o;
  logic [CMDW-1:0] lce_cmd_o;
  logic lce_cmd_v_o, lce_cmd_yumi_i = 1'b0;
  logic [MEMW-1:0] mem_cmd_o;
  logic mem_cmd_v_o, mem_cmd_ready_and_i = 1'b0;
  logic [MEMW-1:0] mem_resp_i = '0;
  logic mem_resp_v_i = 1'b0, mem_resp_yumi_o;

  always #5 clk = ~clk;

  bp_cce_single_lce #(.paddr_width_p(P), .lce_id_width_p(L),
    .cce_id_width_p(C), .sets_p(SETS), .assoc_p(8),
    .block_width_p(B)) dut (
    .clk_i(clk), .reset_i(reset_i), .cce_id_i(cce_id_i),
    .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i),
    .lce_req_yumi_o(lce_req_yumi_o),
    .lce_resp_i(lce_resp_i), .lce_resp_v_i(lce_resp_v_i),
    .lce_resp_yumi_o(lce_resp_yumi_o),
    .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o),
    .lce_cmd_yumi_i(lce_cmd_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o),
    .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o));

  int checks = 0, passes = 0;
  msg_t exp_cmd[$], exp_mem[$];
  logic [P-1:0] clr_log[$];
  msg_t last_cmd, last_mem;
  int cmd_hs = 0, mem_hs = 0;
  bit req_ok = 0, resp_ok = 0, mem_ok = 0;
  bit hold_cmd = 0;

  function automatic void chk(string nm, msg_t act, msg_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic msg_t mk_cmd(int t, logic [P-1:0] a,
      logic [W-1:0] w, logic [1:0] s, logic [B-1:0] d);
    msg_t m = '0;
    m[CMDW-1:0] = {d, s, w, a, CCE, {L{1'b0}}, 3'(t)};
    return m;
  endfunction

  function automatic msg_t mk_mem(int t, logic [P-1:0] a,
      logic [2:0] sz, logic [B-1:0] d);
    msg_t m = '0;
    m[MEMW-1:0] = {d, sz, a, 2'(t)};
    return m;
  endfunction

  function automatic msg_t mk_req(int t, logic [P-1:0] a, bit nx,
      logic [W-1:0] w, bit dirty, logic [2:0] sz, logic [63:0] ud);
    msg_t m = '0;
    m[REQW-1:0] = {ud, sz, dirty, w, nx, a, 2'(t)};
    return m;
  endfunction

  function automatic msg_t mk_resp(int t, logic [P-1:0] a,
      logic [B-1:0] d);
    msg_t m = '0;
    m[RSPW-1:0] = {d, a, 2'(t)};
    return m;
  endfunction

  function automatic logic [B-1:0] rnd_blk();
    logic [B-1:0] d;
    for (int i = 0; i < B/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [P-1:0] align(logic [P-1:0] a);
    return (a >> 6) << 6;
  endfunction

  // LCE / memory acceptance with random backpressure
  always begin
    @(posedge clk); #1;
    lce_cmd_yumi_i = lce_cmd_v_o && !hold_cmd
                     && ($urandom_range(0, 3) != 0);
    mem_cmd_ready_and_i = ($urandom_range(0, 3) != 0);
  end

  // Compare process: every cycle against the expected streams
  always @(negedge clk) begin
    if (!reset_i) begin
      chk("yumi_without_v",
          msg_t'({lce_req_yumi_o & ~lce_req_v_i,
                  lce_resp_yumi_o & ~lce_resp_v_i,
                  mem_resp_yumi_o & ~mem_resp_v_i}), '0);
      if (lce_req_v_i && !req_ok)
        chk("req_stalled", msg_t'(lce_req_yumi_o), '0);
      if (lce_resp_v_i && !resp_ok)
        chk("resp_not_taken", msg_t'(lce_resp_yumi_o), '0);
      if (mem_resp_v_i && !mem_ok)
        chk("mresp_not_taken", msg_t'(mem_resp_yumi_o), '0);
      if (lce_cmd_v_o) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          $display("FAIL lce_cmd_unexpected: got %0h", lce_cmd_o);
        end else chk("lce_cmd", msg_t'(lce_cmd_o), exp_cmd[0]);
        if (lce_cmd_yumi_i) begin
          last_cmd = msg_t'(lce_cmd_o);
          if (lce_cmd_o[2:0] == 3'd1) clr_log.push_back(lce_cmd_o[7 +: P]);
          if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
          cmd_hs++;
        end
      end
      if (mem_cmd_v_o) begin
        if (exp_mem.size() == 0) begin
          checks++;
          $display("FAIL mem_cmd_unexpected: got %0h", mem_cmd_o);
        end else chk("mem_cmd", msg_t'(mem_cmd_o), exp_mem[0]);
        if (mem_cmd_ready_and_i) begin
          last_mem = msg_t'(mem_cmd_o);
          if (exp_mem.size() != 0) void'(exp_mem.pop_front());
          mem_hs++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic offer(int ch, msg_t m, string nm);
    int t = 0;
    case (ch)
      0: begin lce_req_i = m[REQW-1:0]; req_ok = 1; lce_req_v_i = 1; end
      1: begin lce_resp_i = m[RSPW-1:0]; resp_ok = 1; lce_resp_v_i = 1; end
      default: begin mem_resp_i = m[MEMW-1:0]; mem_ok = 1; mem_resp_v_i = 1; end
    endcase
    while (t < 300) begin
      @(negedge clk);
      if ((ch == 0 && lce_req_yumi_o) || (ch == 1 && lce_resp_yumi_o)
          || (ch == 2 && mem_resp_yumi_o)) break;
      t++;
    end
    cyc();
    lce_req_v_i = 0; lce_resp_v_i = 0; mem_resp_v_i = 0;
    req_ok = 0; resp_ok = 0; mem_ok = 0;
    chk({nm, "_accepted"}, msg_t'(t < 300), msg_t'(1));
  endtask

  task automatic wait_hs(int ch, int n, string nm);
    int t = 0;
    while (((ch == 0) ? cmd_hs : mem_hs) < n && t < 1000) begin
      cyc(); t++;
    end
    chk(nm, msg_t'(((ch == 0) ? cmd_hs : mem_hs) >= n), msg_t'(1));
  endtask

  task automatic do_init(bit poke);
    msg_t m;
    exp_cmd.delete(); exp_mem.delete(); clr_log.delete();
    cmd_hs = 0; mem_hs = 0;
    for (int i = 0; i < SETS; i++)
      exp_cmd.push_back(mk_cmd(1, P'(i * 64), '0, 2'd0, '0));
    exp_cmd.push_back(mk_cmd(0, '0, '0, 2'd0, '0));
    reset_i = 1;
    repeat (3) cyc();
    chk("reset_outputs", msg_t'({lce_cmd_v_o, mem_cmd_v_o,
        lce_req_yumi_o, lce_resp_yumi_o, mem_resp_yumi_o}), '0);
    reset_i = 0;
    m = mk_req(0, 40'h1000, 0, 3'd0, 0, 3'd0, '0);
    lce_req_i = m[REQW-1:0];
    lce_req_v_i = 1;
    wait_hs(0, SETS + 1, "init_cmds");
    if (poke) begin
      m = mk_resp(1, '0, '0);
      lce_resp_i = m[RSPW-1:0];
      lce_resp_v_i = 1; mem_resp_v_i = 1;
      repeat (5) cyc();
      lce_resp_v_i = 0; mem_resp_v_i = 0;
    end
    offer(1, mk_resp(0, '0, '0), "sync_ack");
    lce_req_v_i = 0;
    chk("clear_count", msg_t'(clr_log.size()), msg_t'(64));
    chk("clear_first", msg_t'(clr_log[0]), msg_t'(40'h0));
    chk("clear_second", msg_t'(clr_log[1]), msg_t'(40'h40));
    chk("clear_last", msg_t'(clr_log[63]), msg_t'(40'hFC0));
    chk("sync_is_last", msg_t'(last_cmd[2:0]), msg_t'(3'd0));
  endtask

  // kind: 0 rd_miss, 1 uc_rd, 2 uc_wr
  task automatic txn(int kind, bit dirty, bit nullwb, logic [P-1:0] a,
      logic [W-1:0] w, bit nx, logic [2:0] sz, logic [63:0] ud,
      logic [B-1:0] rd);
    logic [B-1:0] vd;
    logic [P-1:0] va, ab;
    int c0, m0;
    ab = align(a);
    vd = rnd_blk();
    va = align({8'($urandom), 32'($urandom)});
    c0 = cmd_hs; m0 = mem_hs;
    if (kind == 0) begin
      if (dirty) exp_cmd.push_back(mk_cmd(2, ab, w, 2'd0, '0));
      if (dirty && !nullwb) exp_mem.push_back(mk_mem(1, va, 3'd6, vd));
      exp_mem.push_back(mk_mem(0, ab, 3'd6, '0));
      exp_cmd.push_back(mk_cmd(3, ab, w, nx ? 2'd1 : 2'd2, rd));
    end else if (kind == 1) begin
      exp_mem.push_back(mk_mem(2, a, sz, '0));
      exp_cmd.push_back(mk_cmd(4, a, '0, 2'd0, rd));
    end else begin
      exp_mem.push_back(mk_mem(3, a, sz, B'(ud)));
      exp_cmd.push_back(mk_cmd(5, a, '0, 2'd0, '0));
    end
    offer(0, mk_req(kind, a, nx, w, dirty, sz, ud), "req");
    if (kind == 0 && dirty) begin
      wait_hs(0, c0 + 1, "wb_cmd");
      offer(1, mk_resp(nullwb ? 3 : 2, va, vd), "wb_resp");
      if (!nullwb) begin
        wait_hs(1, m0 + 1, "wb_mem");
        offer(2, mk_mem(1, va, 3'd6, '0), "wb_ack");
        m0++;
      end
      c0++;
    end
    if (kind == 2) begin
      wait_hs(1, m0 + 1, "uc_wr");
      offer(2, mk_mem(3, a, sz, '0), "uc_wr_ack");
      wait_hs(0, c0 + 1, "uc_done");
    end else begin
      wait_hs(1, m0 + 1, "mem_rd");
      offer(2, mk_mem(0, ab, 3'd6, rd), "rd_data");
      wait_hs(0, c0 + 1, "fill");
      if (kind == 0) offer(1, mk_resp(1, '0, '0), "coh_ack");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, m0, t, k;
    msg_t snap, m;
    logic [B-1:0] rd;
    logic [P-1:0] a;

    do_init(1);

    // Clean rd_miss, pinned literals
    txn(0, 0, 0, 40'h80001040, 3'd3, 0, 3'd0, '0, {64{8'hA5}});
    chk("clean_mem_addr", msg_t'(last_mem[41:2]), msg_t'(40'h80001040));
    chk("clean_mem_type", msg_t'(last_mem[1:0]), msg_t'(2'd0));
    chk("clean_dt_way", msg_t'(last_cmd[49:47]), msg_t'(3'd3));
    chk("clean_dt_state", msg_t'(last_cmd[51:50]), msg_t'(2'd2));
    chk("clean_dt_data", msg_t'(last_cmd[563:52]), msg_t'({64{8'hA5}}));

    // Dirty rd_miss: resp_wb then resp_null_wb
    m0 = mem_hs;
    txn(0, 1, 0, 40'h00002080, 3'd1, 0, 3'd0, '0, rnd_blk());
    chk("dirty_wb_mem_cnt", msg_t'(mem_hs - m0), msg_t'(2));
    m0 = mem_hs;
    txn(0, 1, 1, 40'h00003100, 3'd1, 1, 3'd0, '0, rnd_blk());
    chk("dirty_null_mem_cnt", msg_t'(mem_hs - m0), msg_t'(1));

    // uc store
    c0 = cmd_hs;
    txn(2, 0, 0, 40'h00100000, 3'd0, 0, 3'd3, 64'hDEADBEEF, '0);
    chk("ucwr_type", msg_t'(last_mem[1:0]), msg_t'(2'd3));
    chk("ucwr_size", msg_t'(last_mem[44:42]), msg_t'(3'd3));
    chk("ucwr_addr", msg_t'(last_mem[41:2]), msg_t'(40'h00100000));
    chk("ucwr_data", msg_t'(last_mem[556:45]), msg_t'(64'hDEADBEEF));
    chk("ucwr_one_done", msg_t'(cmd_hs - c0), msg_t'(1));
    chk("ucwr_done_type", msg_t'(last_cmd[2:0]), msg_t'(3'd5));

    // Backpressure on fill
    hold_cmd = 1;
    c0 = cmd_hs; m0 = mem_hs;
    a = 40'h00004200; rd = rnd_blk();
    exp_mem.push_back(mk_mem(0, a, 3'd6, '0));
    exp_cmd.push_back(mk_cmd(3, a, 3'd5, 2'd2, rd));
    offer(0, mk_req(0, a, 0, 3'd5, 0, 3'd0, '0), "bp_req");
    wait_hs(1, m0 + 1, "bp_mem_rd");
    offer(2, mk_mem(0, a, 3'd6, rd), "bp_rd_data");
    t = 0;
    while (!lce_cmd_v_o && t < 50) begin cyc(); t++; end
    chk("bp_fill_v", msg_t'(lce_cmd_v_o), msg_t'(1));
    snap = msg_t'(lce_cmd_o);
    m = mk_req(1, 40'h5000, 0, 3'd0, 0, 3'd2, '0);
    lce_req_i = m[REQW-1:0];
    lce_req_v_i = 1;
    repeat (10) begin
      cyc();
      chk("bp_v_held", msg_t'(lce_cmd_v_o), msg_t'(1));
      chk("bp_stable", msg_t'(lce_cmd_o), snap);
    end
    lce_req_v_i = 0;
    hold_cmd = 0;
    wait_hs(0, c0 + 1, "bp_fill");
    offer(1, mk_resp(1, '0, '0), "bp_coh_ack");

    // Random transactions
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      txn(k, 1'($urandom), 1'($urandom),
          {8'($urandom), 32'($urandom)}, 3'($urandom), 1'($urandom),
          3'($urandom_range(0, 3)), {32'($urandom), 32'($urandom)},
          rnd_blk());
    end

    // Reset in the middle of a read
    m0 = mem_hs;
    a = 40'h00006000;
    exp_mem.push_back(mk_mem(0, a, 3'd6, '0));
    offer(0, mk_req(0, a, 0, 3'd2, 0, 3'd0, '0), "rst_req");
    wait_hs(1, m0 + 1, "rst_mem_rd");
    reset_i = 1;
    cyc();
    chk("rst_valids_low", msg_t'({lce_cmd_v_o, mem_cmd_v_o,
        lce_req_yumi_o, lce_resp_yumi_o, mem_resp_yumi_o}), '0);
    do_init(0);
    txn(1, 0, 0, 40'h00007008, 3'd0, 0, 3'd2, '0, rnd_blk());

    repeat (3) cyc();
    chk("cmd_queue_drained", msg_t'(exp_cmd.size()), '0);
    chk("mem_queue_drained", msg_t'(exp_mem.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
